// File: rtl/memory_bank_pkg.sv
// Shared constants for the memory bank: command encodings and default geometry.
package memory_bank_pkg;

  localparam logic [1:0] MEMORY_MODE_NOP   = 2'b00;
  localparam logic [1:0] MEMORY_MODE_READ  = 2'b01;
  localparam logic [1:0] MEMORY_MODE_WRITE = 2'b10;
  localparam logic [1:0] MEMORY_MODE_CLEAR = 2'b11;

  localparam int MEMORY_WIDTH     = 4;
  localparam int MEMORY_ADDR_BITS = 4;

endpackage

// File: rtl/memory_bank.sv
// Single-port word memory with registered read and a self-timed clear sweep
// that also initialises the array after reset.
module memory_bank
  import memory_bank_pkg::*;
#(
  parameter int               WIDTH       = MEMORY_WIDTH,
  parameter int               ADDR_BITS   = MEMORY_ADDR_BITS,
  parameter logic [WIDTH-1:0] CLEAR_VALUE = '0
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [1:0]           mode,
  input  logic [ADDR_BITS-1:0] address,
  input  logic [WIDTH-1:0]     data_in,
  output logic [WIDTH-1:0]     data_out,
  output logic                 rd_valid,
  output logic                 busy,
  output logic                 cmd_dropped
);

  localparam int DEPTH = 2 ** ADDR_BITS;

  typedef enum logic {
    SWEEP = 1'b0,
    IDLE  = 1'b1
  } state_t;

  state_t               state;
  logic [ADDR_BITS-1:0] ptr;
  logic [WIDTH-1:0]     mem [DEPTH];

  // The array has no reset term; the sweep entered on reset initialises it.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= SWEEP;
      busy        <= 1'b1;
      ptr         <= '0;
      data_out    <= CLEAR_VALUE;
      rd_valid    <= 1'b0;
      cmd_dropped <= 1'b0;
    end else begin
      case (state)
        SWEEP: begin
          mem[ptr]    <= CLEAR_VALUE;
          rd_valid    <= 1'b0;
          cmd_dropped <= (mode != MEMORY_MODE_NOP);
          if (&ptr) begin
            state <= IDLE;
            busy  <= 1'b0;
            ptr   <= '0;
          end else begin
            ptr <= ptr + 1'b1;
          end
        end
        default: begin
          cmd_dropped <= 1'b0;
          rd_valid    <= 1'b0;
          case (mode)
            MEMORY_MODE_READ: begin
              data_out <= mem[address];
              rd_valid <= 1'b1;
            end
            MEMORY_MODE_WRITE: mem[address] <= data_in;
            MEMORY_MODE_CLEAR: begin
              data_out <= CLEAR_VALUE;
              ptr      <= '0;
              state    <= SWEEP;
              busy     <= 1'b1;
            end
            default: ;
          endcase
        end
      endcase
    end
  end

endmodule

// File: tb/tb_memory_bank.sv
// Randomised and directed bench for memory_bank, run on a 4x16 and an 8x8 instance
// in lock-step against a countdown-based reference model.
module tb_memory_bank;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [1:0] mode = 2'b00;
  logic [3:0] addr_a = '0;
  logic [2:0] addr_b = '0;
  logic [3:0] din_a = '0;
  logic [7:0] din_b = '0;
  logic [3:0] dout_a;
  logic [7:0] dout_b;
  logic       rv_a, rv_b, busy_a, busy_b, cd_a, cd_b;

  int checks = 0;
  int passed = 0;

  always #5 clk = ~clk;

  memory_bank dut_a (
    .clk(clk), .rst(rst), .mode(mode), .address(addr_a), .data_in(din_a),
    .data_out(dout_a), .rd_valid(rv_a), .busy(busy_a), .cmd_dropped(cd_a)
  );

  memory_bank #(.WIDTH(8), .ADDR_BITS(3), .CLEAR_VALUE(8'hFF)) dut_b (
    .clk(clk), .rst(rst), .mode(mode), .address(addr_b), .data_in(din_b),
    .data_out(dout_b), .rd_valid(rv_b), .busy(busy_b), .cmd_dropped(cd_b)
  );

  // Reference model: index 0 is the 4x16 instance, index 1 the 8x8 instance.
  int depth [2] = '{16, 8};
  int cval  [2] = '{0, 255};
  int dmask [2] = '{15, 255};
  int mem_m [2][16];
  int sweep_left [2];
  int exp_dout [2];
  int exp_rv [2];
  int exp_cd [2];

  task automatic chk(input string tag, input int obs, input int exp);
    checks++;
    if (obs == exp) passed++;
    else $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
  endtask

  task automatic model_edge(input int k, input logic r, input logic [1:0] m,
                            input int a, input int d);
    if (r) begin
      sweep_left[k] = depth[k];
      exp_dout[k]   = cval[k];
      exp_rv[k]     = 0;
      exp_cd[k]     = 0;
    end else if (sweep_left[k] > 0) begin
      mem_m[k][depth[k] - sweep_left[k]] = cval[k];
      sweep_left[k] = sweep_left[k] - 1;
      exp_rv[k] = 0;
      exp_cd[k] = (m != 2'b00) ? 1 : 0;
    end else begin
      exp_cd[k] = 0;
      exp_rv[k] = 0;
      case (m)
        2'b01: begin exp_dout[k] = mem_m[k][a]; exp_rv[k] = 1; end
        2'b10: mem_m[k][a] = d;
        2'b11: begin exp_dout[k] = cval[k]; sweep_left[k] = depth[k]; end
        default: ;
      endcase
    end
  endtask

  task automatic step(input logic r, input logic [1:0] m, input logic [3:0] a,
                      input logic [7:0] d);
    rst = r; mode = m; addr_a = a; addr_b = a[2:0]; din_a = d[3:0]; din_b = d;
    @(posedge clk);
    for (int k = 0; k < 2; k++)
      model_edge(k, r, m, int'(a) % depth[k], int'(d) & dmask[k]);
    #1;
    chk("dout_a", int'(dout_a), exp_dout[0]);
    chk("rv_a",   int'(rv_a),   exp_rv[0]);
    chk("busy_a", int'(busy_a), (sweep_left[0] > 0) ? 1 : 0);
    chk("cd_a",   int'(cd_a),   exp_cd[0]);
    chk("dout_b", int'(dout_b), exp_dout[1]);
    chk("rv_b",   int'(rv_b),   exp_rv[1]);
    chk("busy_b", int'(busy_b), (sweep_left[1] > 0) ? 1 : 0);
    chk("cd_b",   int'(cd_b),   exp_cd[1]);
  endtask

  // Steps NOPs until both instances are idle; returns busy lengths of each.
  task automatic count_sweep(output int na, output int nb);
    na = 0; nb = 0;
    while ((busy_a || busy_b) && na < 40) begin
      if (busy_a) na++;
      if (busy_b) nb++;
      step(1'b0, 2'b00, 4'd0, 8'd0);
    end
  endtask

  initial begin
    int na, nb;
    for (int k = 0; k < 2; k++)
      for (int i = 0; i < 16; i++) mem_m[k][i] = 0;

    // Reset and post-reset initialisation sweep
    step(1'b1, 2'b10, 4'd5, 8'h33);
    step(1'b1, 2'b01, 4'd2, 8'h00);
    count_sweep(na, nb);
    chk("init_sweep_len_a", na, 16);
    chk("init_sweep_len_b", nb, 8);
    for (int i = 0; i < 16; i++) step(1'b0, 2'b01, 4'(i), 8'h00);
    step(1'b0, 2'b00, 4'd0, 8'h00);

    // Write then read-back, neighbour untouched, wide write on the small instance
    step(1'b0, 2'b10, 4'd3, 8'h0A);
    step(1'b0, 2'b01, 4'd3, 8'h00);
    step(1'b0, 2'b01, 4'd4, 8'h00);
    step(1'b0, 2'b10, 4'd7, 8'h5C);
    step(1'b0, 2'b01, 4'd7, 8'h00);
    step(1'b0, 2'b01, 4'd6, 8'h00);

    // Fill with addr^5, clear with a write dropped during the sweep
    for (int i = 0; i < 16; i++) step(1'b0, 2'b10, 4'(i), 8'(i ^ 5));
    step(1'b0, 2'b11, 4'd0, 8'h00);
    step(1'b0, 2'b10, 4'd9, 8'hEE);
    count_sweep(na, nb);
    chk("clear_sweep_len_a", na + 1, 16);
    chk("clear_sweep_len_b", nb + 1, 8);
    for (int i = 0; i < 16; i++) step(1'b0, 2'b01, 4'(i), 8'h00);

    // Reset in the middle of a clear sweep restarts it
    for (int i = 0; i < 16; i++) step(1'b0, 2'b10, 4'(i), 8'(i * 3));
    step(1'b0, 2'b11, 4'd0, 8'h00);
    for (int i = 0; i < 6; i++) step(1'b0, 2'b00, 4'd0, 8'h00);
    step(1'b1, 2'b01, 4'd1, 8'h00);
    count_sweep(na, nb);
    chk("rst_sweep_len_a", na, 16);
    chk("rst_sweep_len_b", nb, 8);
    for (int i = 0; i < 16; i++) step(1'b0, 2'b01, 4'(i), 8'h00);

    // Back-to-back reads followed by a NOP
    step(1'b0, 2'b10, 4'd1, 8'h11);
    step(1'b0, 2'b10, 4'd2, 8'h22);
    step(1'b0, 2'b10, 4'd3, 8'h33);
    step(1'b0, 2'b01, 4'd1, 8'h00);
    step(1'b0, 2'b01, 4'd2, 8'h00);
    step(1'b0, 2'b01, 4'd3, 8'h00);
    step(1'b0, 2'b00, 4'd0, 8'h00);

    // Randomised traffic with occasional clears and resets
    for (int n = 0; n < 1500; n++) begin
      int         roll;
      logic [1:0] m;
      roll = int'($urandom_range(0, 99));
      m = (roll < 4) ? 2'b11 : 2'($urandom_range(0, 2));
      step(($urandom_range(0, 127) == 0), m, 4'($urandom), 8'($urandom));
    end

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
